// File: rtl/register_file.sv
// Register file next to the ALU: two combinational read ports, one write-back port, a flag
// register and a two-cycle swap sequencer. Define REGFILE_WRITE_BYPASS_EN for write-to-read bypass.
`timescale 1ns/1ps

module register_file #(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned NUM_REGS       = 4,
    parameter int unsigned ADDR_WIDTH     = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     rd_addr1,
    output logic [DATA_BUS_WIDTH-1:0] rd_data1,
    input  logic [ADDR_WIDTH-1:0]     rd_addr2,
    output logic [DATA_BUS_WIDTH-1:0] rd_data2,

    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_BUS_WIDTH-1:0] wr_data,

    // Flag bit order is {alu_carry, alu_zero}.
    input  logic                      flag_we,
    input  logic [1:0]                flag_in,
    output logic [1:0]                flag_out,

    input  logic                      swap_req,
    input  logic [ADDR_WIDTH-1:0]     swap_a,
    input  logic [ADDR_WIDTH-1:0]     swap_b,
    output logic                      busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSwap1,
        StSwap2
    } state_e;

    state_e                    state_q;
    logic [DATA_BUS_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_BUS_WIDTH-1:0] temp_q;
    logic [ADDR_WIDTH-1:0]     swap_b_q;
    logic [1:0]                flag_q;
    logic                      busy_q;
    logic                      wr_fire;

    // A swap request in the same idle cycle takes the write port, so the write-back is lost.
    assign wr_fire = wr_en && (state_q == StIdle) && !swap_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            temp_q   <= '0;
            swap_b_q <= '0;
            flag_q   <= '0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
        end else begin
            if (flag_we) begin
                flag_q <= flag_in;
            end
            unique case (state_q)
                StIdle: begin
                    if (swap_req) begin
                        temp_q         <= regs_q[swap_a];
                        regs_q[swap_a] <= regs_q[swap_b];
                        swap_b_q       <= swap_b;
                        busy_q         <= 1'b1;
                        state_q        <= StSwap1;
                    end else if (wr_fire) begin
                        regs_q[wr_addr] <= wr_data;
                    end
                end
                StSwap1: begin
                    regs_q[swap_b_q] <= temp_q;
                    busy_q           <= 1'b0;
                    state_q          <= StSwap2;
                end
                StSwap2: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_fire && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
        if (wr_fire && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
`endif
    end

    assign flag_out = flag_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected values, a monitor compares them.
`timescale 1ns/1ps

module tb_register_file;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rd_addr1, rd_addr2, wr_addr, swap_a, swap_b;
    logic [7:0] rd_data1, rd_data2, wr_data;
    logic       wr_en, flag_we, swap_req, busy;
    logic [1:0] flag_in, flag_out;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flag_we  (flag_we),
        .flag_in  (flag_in),
        .flag_out (flag_out),
        .swap_req (swap_req),
        .swap_a   (swap_a),
        .swap_b   (swap_b),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {KRd1, KRd2, KFlag, KBusy} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] exp;
        string      name;
    } item_t;

    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    event  chk_ev;

    initial begin : monitor
        item_t      it;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.kind)
                    KRd1:    act = rd_data1;
                    KRd2:    act = rd_data2;
                    KFlag:   act = {6'b0, flag_out};
                    default: act = {7'b0, busy};
                endcase
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_val(input kind_e k, input logic [7:0] v, input string n);
        item_t it;
        it.kind = k;
        it.exp  = v;
        it.name = n;
        sb_q.push_back(it);
    endtask

    task automatic sample();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin : stim
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0; wr_en = 1'b0;
        flag_we = 1'b0; flag_in = '0; swap_req = 1'b0; swap_a = '0; swap_b = '0;
        step();
        rst = 1'b0;
        expect_val(KRd1, 8'h00, "reset_rd1");
        expect_val(KRd2, 8'h00, "reset_rd2");
        expect_val(KFlag, 8'h00, "reset_flag");
        expect_val(KBusy, 8'h00, "reset_busy");
        sample();

        // Write-back and read
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hA5; rd_addr1 = 2'd1;
        expect_val(KRd1, Bypass ? 8'hA5 : 8'h00, "same_cycle_r1");
        sample();
        step();
        wr_addr = 2'd2; wr_data = 8'h3C; rd_addr2 = 2'd2;
        expect_val(KRd1, 8'hA5, "r1_after_write");
        sample();
        step();
        wr_en = 1'b0;
        expect_val(KRd2, 8'h3C, "r2_after_write");
        sample();

        // Flags: carry set, then hold while flag_we low
        flag_we = 1'b1; flag_in = 2'b10;
        step();
        flag_we = 1'b0; flag_in = 2'b01;
        expect_val(KFlag, 8'h02, "flag_load");
        sample();
        step();
        expect_val(KFlag, 8'h02, "flag_hold");
        sample();

        // Asynchronous reset mid-cycle, checked before the next rising edge
        step();
        #1 rst = 1'b1;
        expect_val(KRd1, 8'h00, "async_rst_rd1");
        expect_val(KRd2, 8'h00, "async_rst_rd2");
        expect_val(KFlag, 8'h00, "async_rst_flag");
        expect_val(KBusy, 8'h00, "async_rst_busy");
        sample();
        rst = 1'b0;

        // Swap r0/r3 with a conflicting write to r1
        step();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h11;
        step();
        wr_addr = 2'd3; wr_data = 8'hEE;
        step();
        wr_en = 1'b0; rd_addr1 = 2'd0; rd_addr2 = 2'd3;
        expect_val(KRd1, 8'h11, "pre_swap_r0");
        expect_val(KRd2, 8'hEE, "pre_swap_r3");
        expect_val(KBusy, 8'h00, "pre_swap_busy");
        sample();
        swap_req = 1'b1; swap_a = 2'd0; swap_b = 2'd3;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
        step();
        // In SWAP1: second request, write and flag load all presented
        swap_req = 1'b1; swap_a = 2'd0; swap_b = 2'd1;
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h99;
        flag_we = 1'b1; flag_in = 2'b01;
        expect_val(KBusy, 8'h01, "busy_swap1");
        expect_val(KRd1, 8'hEE, "swap_r0_mid");
        expect_val(KRd2, 8'hEE, "no_bypass_in_swap");
        sample();
        step();
        swap_req = 1'b0; wr_en = 1'b0; flag_we = 1'b0;
        expect_val(KBusy, 8'h00, "busy_swap2");
        expect_val(KRd1, 8'hEE, "swap_r0");
        expect_val(KRd2, 8'h11, "swap_r3");
        expect_val(KFlag, 8'h01, "flag_during_swap");
        sample();
        rd_addr1 = 2'd1;
        expect_val(KRd1, 8'h00, "conflict_write_dropped");
        sample();
        step();
        step();
        rd_addr2 = 2'd0;
        expect_val(KRd1, 8'h00, "second_swap_ignored_r1");
        expect_val(KRd2, 8'hEE, "second_swap_ignored_r0");
        expect_val(KBusy, 8'h00, "second_swap_not_queued");
        sample();

        // Self-swap leaves contents unchanged
        swap_req = 1'b1; swap_a = 2'd3; swap_b = 2'd3;
        step();
        swap_req = 1'b0;
        expect_val(KBusy, 8'h01, "self_swap_busy");
        sample();
        step();
        step();
        rd_addr2 = 2'd3;
        expect_val(KRd2, 8'h11, "self_swap_r3");
        sample();

        // Reset in SWAP1 aborts the exchange
        swap_req = 1'b1; swap_a = 2'd0; swap_b = 2'd3; rd_addr1 = 2'd0;
        step();
        swap_req = 1'b0;
        #1 rst = 1'b1;
        expect_val(KRd1, 8'h00, "abort_r0");
        expect_val(KRd2, 8'h00, "abort_r3");
        expect_val(KBusy, 8'h00, "abort_busy");
        sample();
        rst = 1'b0;
        step();
        expect_val(KBusy, 8'h00, "abort_idle_busy");
        expect_val(KRd2, 8'h00, "abort_no_partial");
        sample();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h42;
        step();
        wr_en = 1'b0; rd_addr2 = 2'd2;
        expect_val(KRd2, 8'h42, "write_after_abort");
        sample();

        // Same-cycle read of the write target, both ports on one address
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A; rd_addr1 = 2'd2;
        expect_val(KRd2, Bypass ? 8'h5A : 8'h42, "bypass_rd2");
        expect_val(KRd1, Bypass ? 8'h5A : 8'h42, "bypass_rd1");
        sample();
        step();
        wr_en = 1'b0;
        expect_val(KRd1, 8'h5A, "same_addr_rd1");
        expect_val(KRd2, 8'h5A, "same_addr_rd2");
        sample();

        step();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
